// File: rtl/johnson_pkg.sv
// Shared types and sizing helpers for the Johnson-counter phase decoder.
// Holds the tracker state enum, default geometry and width functions.
package johnson_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_LOCK_CNT = 3;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  // Bits needed to hold a phase index 0..2N-1.
  function automatic int phase_w(input int n);
    return (n < 1) ? 1 : $clog2(2 * n);
  endfunction

  // Bits needed to hold the good-successor counter 0..lock_cnt.
  function automatic int cnt_w(input int lock_cnt);
    return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/johnson_word_decode.sv
// Combinational decode of an N-bit Johnson word into {legal, phase}.
// A word is legal when its ones (MSB=0) or zeros (MSB=1) form one run from the LSB.
module johnson_word_decode
  import johnson_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]          count_in,
  output logic                  legal,
  output logic [phase_w(N)-1:0] phase
);

  localparam int PW = phase_w(N);

  logic         msb;
  logic [N-1:0] norm;
  logic [PW-1:0] ones;

  always_comb begin
    // NOTE: every output and temporary gets a value before any branch, so no latch is inferred.
    msb   = count_in[N-1];
    norm  = msb ? ~count_in : count_in;
    ones  = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + PW'(count_in[i]);
    end
    // A thermometer code 0..01..1 is the only pattern with no overlap against itself plus one.
    legal = ((norm & (norm + N'(1))) == '0);
    phase = msb ? (PW'(N) + (PW'(N) - ones)) : ones;
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-counter phase decoder with sequence tracking, lock detection and
// a saturating error counter. All outputs are registered.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          count_in,
  input  logic                  valid_in,
  input  logic                  clr_err,
  output logic [phase_w(N)-1:0] phase,
  output logic                  phase_valid,
  output logic                  illegal,
  output logic                  seq_err,
  output logic                  locked,
  output logic [7:0]            err_count
);

  localparam int              PW       = phase_w(N);
  localparam int              GW       = cnt_w(LOCK_CNT);
  localparam logic [PW-1:0]   LAST_PH  = PW'(2 * N - 1);
  localparam logic [GW-1:0]   LOCK_VAL = GW'(LOCK_CNT);

  state_e        state_q, state_d;
  logic [PW-1:0] ref_q, ref_d;
  logic [GW-1:0] good_q, good_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          pv_q, pv_d;
  logic          ill_q, ill_d;
  logic          seq_q, seq_d;
  logic [7:0]    err_q, err_d;

  logic          word_legal;
  logic [PW-1:0] word_phase;
  logic [PW-1:0] exp_phase;
  logic [GW-1:0] good_inc;
  logic          err_evt;

  johnson_word_decode #(.N(N)) u_decode (
    .count_in (count_in),
    .legal    (word_legal),
    .phase    (word_phase)
  );

  assign exp_phase = (ref_q == LAST_PH) ? '0 : ref_q + PW'(1);
  assign good_inc  = good_q + GW'(1);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    phase_d = phase_q;
    pv_d    = pv_q;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    err_evt = 1'b0;

    if (valid_in) begin
      if (!word_legal) begin
        // Phase is held; the reference is invalidated by returning to UNLOCKED.
        ill_d   = 1'b1;
        pv_d    = 1'b0;
        err_evt = 1'b1;
        state_d = ST_UNLOCKED;
        good_d  = '0;
      end else begin
        phase_d = word_phase;
        pv_d    = 1'b1;
        ref_d   = word_phase;
        unique case (state_q)
          ST_UNLOCKED: begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
          ST_ACQUIRE, ST_LOCKED: begin
            if (word_phase == exp_phase) begin
              if (state_q == ST_ACQUIRE) begin
                good_d = good_inc;
                if (good_inc == LOCK_VAL) state_d = ST_LOCKED;
              end
            end else begin
              seq_d   = 1'b1;
              err_evt = 1'b1;
              state_d = ST_ACQUIRE;
              good_d  = '0;
            end
          end
          default: begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end
        endcase
      end
    end

    // A clear on the same edge as an error leaves that one error counted.
    if (clr_err)                       err_d = {7'd0, err_evt};
    else if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
    else                               err_d = err_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!reset) begin
      state_q <= ST_UNLOCKED;
      ref_q   <= '0;
      good_q  <= '0;
      phase_q <= '0;
      pv_q    <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      good_q  <= good_d;
      phase_q <= phase_d;
      pv_q    <= pv_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = pv_q;
  assign illegal     = ill_q;
  assign seq_err     = seq_q;
  assign locked      = (state_q == ST_LOCKED);
  assign err_count   = err_q;

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter N, default 4, counter width in bits; phase space is 2N states.
REQ-002 Parameter LOCK_CNT, default 3, consecutive correct successors required to declare lock.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 count_in  input  N  Johnson code word from the counter under observation.
REQ-007 valid_in  input  1  count_in is sampled on this edge.
REQ-008 clr_err  input  1  clears err_count.
REQ-009 phase  output  clog2(2N)  decoded phase index 0..2N-1.
REQ-010 phase_valid  output  1  phase is meaningful, i.e. the last sample was legal.
REQ-011 illegal  output  1  last sample was not a legal Johnson word.
REQ-012 seq_err  output  1  last sample was legal but not the expected successor.
REQ-013 locked  output  1  tracker is in LOCKED.
REQ-014 err_count  output  8  saturating count of illegal or seq_err events.

Function
REQ-015 Legal words SHALL be the 2N words of sequence next = {cur[N-2:0], ~cur[N-1]} from all-zeros; for N=4: 0000,0001,0011,0111,1111,1110,1100,1000.
REQ-016 Decode SHALL be: MSB=0 -> phase = number of ones; MSB=1 -> phase = N + number of zeros.
REQ-017 All outputs SHALL be registered, updating one clk after the edge that samples valid_in=1.
REQ-018 On valid_in=0, phase/phase_valid/locked SHALL hold; illegal and seq_err SHALL be 0 (single-cycle pulses).
REQ-019 Expected phase SHALL be (ref_phase+1) mod 2N, wrapping 2N-1 -> 0; ref_phase is the last legal sampled phase.
REQ-020 A repeated legal word (phase == ref_phase) SHALL be a seq_err.
REQ-021 An illegal word SHALL assert illegal, clear phase_valid, hold phase, never assert seq_err, and invalidate the reference.
REQ-022 FSM states UNLOCKED, ACQUIRE, LOCKED; good_cnt counts correct successors.
REQ-023 UNLOCKED: legal sample -> ACQUIRE, set reference, good_cnt=0, no seq_err check; illegal -> stay.
REQ-024 ACQUIRE: correct successor -> good_cnt+1, LOCKED when it reaches LOCK_CNT; seq_err -> stay, re-reference, good_cnt=0; illegal -> UNLOCKED.
REQ-025 LOCKED: correct successor -> stay; seq_err -> ACQUIRE, re-reference, good_cnt=0; illegal -> UNLOCKED.
REQ-026 err_count SHALL increment by 1 per illegal or seq_err event and saturate at 255.
REQ-027 clr_err and an error on the same edge SHALL yield err_count=1; clr_err alone SHALL yield 0.

Reset
REQ-028 reset=0 at a clk edge SHALL force: phase=0, phase_valid=0, illegal=0, seq_err=0, locked=0, err_count=0, FSM=UNLOCKED, good_cnt=0, reference invalid.
REQ-029 Reset SHALL override valid_in and clr_err on the same edge; mid-sequence reset SHALL require full re-acquisition.

Structure
REQ-030 Package johnson_pkg SHALL hold the FSM state enum, default N and LOCK_CNT, and the phase-width constant function.
REQ-031 Combinational sub-module johnson_word_decode SHALL map count_in to {legal, phase}; johnson_decoder owns all registers.

Verification
REQ-032 Reset released, feed 0000,0001,0011,0111 on consecutive cycles -> locked=1 one cycle after 0111 is sampled, phase=3, err_count=0.
REQ-033 Locked, feed 1000 then 0000 -> phase 7 then 0, no seq_err (wrap-around).
REQ-034 Locked at phase 2 (0011), feed 1111 -> seq_err pulse, locked=0, phase=4, err_count=1; then 1110,1100,1000 -> relocked.
REQ-035 Feed 0101 -> illegal=1, phase_valid=0, phase held, FSM UNLOCKED, err_count+1.
REQ-036 Force 260 alternating illegal words -> err_count=255; then clr_err with an illegal word on the same edge -> err_count=1.
REQ-037 Locked mid-sequence, assert reset=0 for one edge with valid_in=1 -> all outputs at reset values; next legal word -> ACQUIRE, no seq_err.
